// File: rtl/matmul_result_collector.sv
// Collects N*N scalar products in row-major order into one packed matrix and
// hands it downstream with a valid/ready handshake; no input bypass while full.
module matmul_result_collector #(
  parameter int unsigned Nbits = 4,
  parameter int unsigned N     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [2*Nbits-1:0]         in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N*N*2*Nbits-1:0]     out_matrix,
  output logic [$clog2(N*N):0]       fill_count
);

  localparam int unsigned W     = 2 * Nbits;
  localparam int unsigned Elems = N * N;
  localparam int unsigned CntW  = $clog2(Elems) + 1;

  typedef enum logic {StCollect, StFull} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [Elems*W-1:0]      mat_q, mat_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    if (clear) begin
      state_d = StCollect;
      cnt_d   = '0;
      mat_d   = '0;
    end else begin
      unique case (state_q)
        StCollect: begin
          if (in_valid) begin
            for (int k = 0; k < Elems; k++) begin
              if (cnt_q == CntW'(k)) mat_d[k*W +: W] = in_data;
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(Elems - 1)) state_d = StFull;
          end
        end
        StFull: begin
          // Handoff only; the buffer keeps its contents until overwritten.
          if (out_ready) begin
            state_d = StCollect;
            cnt_d   = '0;
          end
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StCollect;
      cnt_q   <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mat_q   <= mat_d;
    end
  end

  assign in_ready   = (state_q == StCollect);
  assign out_valid  = (state_q == StFull);
  assign out_matrix = mat_q;
  assign fill_count = cnt_q;

endmodule

// File: tb/tb_matmul_result_collector.sv
// Randomized and directed bench for matmul_result_collector against an
// element-array reference model (N=2, Nbits=4).
module tb_matmul_result_collector;

  localparam int unsigned Nbits = 4;
  localparam int unsigned N     = 2;
  localparam int unsigned W     = 2 * Nbits;
  localparam int unsigned Elems = N * N;
  localparam int unsigned MW    = Elems * W;
  localparam int unsigned CW    = $clog2(Elems) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] out_matrix;
  logic [CW-1:0] fill_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: matrix element values and number stored so far.
  int unsigned mdl_mat [Elems];
  int unsigned mdl_cnt = 0;

  matmul_result_collector #(.Nbits(Nbits), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] model_packed();
    logic [MW-1:0] p = '0;
    for (int k = 0; k < Elems; k++) p[k*W +: W] = W'(mdl_mat[k]);
    return p;
  endfunction

  task automatic model_clear();
    mdl_cnt = 0;
    for (int k = 0; k < Elems; k++) mdl_mat[k] = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".fill_count"}, 64'(fill_count), 64'(mdl_cnt));
    check_eq({tag, ".out_valid"}, 64'(out_valid), 64'(mdl_cnt == Elems));
    check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(mdl_cnt != Elems));
    check_eq({tag, ".out_matrix"}, 64'(out_matrix), 64'(model_packed()));
  endtask

  // One clock: apply inputs, advance the model at the edge, compare after it.
  task automatic step(input logic iv, input int unsigned d, input logic ordy, input logic clr,
                      input string tag);
    in_valid  = iv;
    in_data   = W'(d);
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    if (clr) begin
      model_clear();
    end else if (mdl_cnt == Elems) begin
      if (ordy) mdl_cnt = 0;
    end else if (iv) begin
      mdl_mat[mdl_cnt] = d;
      mdl_cnt++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    model_clear();
    #2;
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b1;

    // Basic fill
    step(1, 12, 0, 0, "fill0");
    step(1, 20, 0, 0, "fill1");
    step(1, 77, 0, 0, "fill2");
    step(1, 200, 0, 0, "fill3");
    check_eq("basic_matrix", 64'(out_matrix), 64'h00000000_C84D140C);

    // Backpressure: 99 offered but never taken while full
    for (int i = 0; i < 10; i++) step(1, 99, 0, 0, "bp_hold");
    check_eq("bp_matrix", 64'(out_matrix), 64'h00000000_C84D140C);
    // Handoff edge with in_valid: 50 must not be taken that edge
    step(1, 50, 1, 0, "handoff");
    step(1, 50, 0, 0, "b2b_first");
    check_eq("b2b_elem0", 64'(out_matrix[W-1:0]), 64'd50);

    // Gapped input after clearing
    step(0, 0, 0, 1, "clr_a");
    step(1, 5, 0, 0, "gap0");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "gap_idle");
    step(1, 7, 0, 0, "gap1");
    step(1, 9, 0, 0, "gap2");
    step(1, 11, 0, 0, "gap3");
    check_eq("gap_matrix", 64'(out_matrix), 64'h00000000_0B090705);

    // Clear mid-fill wins over accept
    step(1, 0, 1, 0, "drain");
    step(1, 1, 0, 0, "cm0");
    step(1, 2, 0, 0, "cm1");
    step(1, 3, 0, 1, "cm_clear");
    check_eq("cm_zero", 64'(out_matrix), 64'd0);
    step(1, 4, 0, 0, "cm2");
    step(1, 5, 0, 0, "cm3");
    step(1, 6, 0, 0, "cm4");
    step(1, 7, 0, 0, "cm5");
    check_eq("cm_matrix", 64'(out_matrix), 64'h00000000_07060504);

    // Async reset while full, between edges
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step(1, 33, 0, 0, "post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 3) != 0), $urandom_range(0, 255),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 29) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
